// File: rtl/hex_seg_pkg.sv
// hex_seg_pkg
//   Shared constants for the HEX segment driver: Avalon-MM register
//   addresses, CTRL bit positions and the reset value of every register.
//   Imported by hex_seg_driver.
package hex_seg_pkg;

    // Register map
    localparam logic [1:0] ADDR_CTRL      = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT    = 2'd1;
    localparam logic [1:0] ADDR_BLINK_DIV = 2'd2;
    localparam logic [1:0] ADDR_STATUS    = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_INVERT   = 2;

    // Reset values
    localparam logic [2:0] CTRL_RST        = 3'b101;   // enabled, no blink, inverted
    localparam logic [3:0] BRIGHT_RST      = 4'hF;     // full brightness
    localparam logic [7:0] BLINK_DIV_RST   = 8'd250;
    localparam logic       BLINK_PHASE_RST = 1'b1;     // "visible" phase
    localparam logic [6:0] SEG_OUT_RST     = 7'h7F;    // all segments off (pins active-low)

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Free-running counter 0..PRESCALE-1 producing a one-cycle tick while the
//   count sits at PRESCALE-1; the counter wraps to 0 on the following edge.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset (count -> 0)
//     tick     out  one-cycle strobe, high while count == PRESCALE-1
//   PRESCALE legal range is 2..65535, so a 16-bit counter always suffices.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/hex_seg_driver.sv
// hex_seg_driver
//   Sits between a HEX PIO and the 7-segment pins. Adds enable, PWM
//   brightness, blinking and output inversion, all controlled through a
//   small Avalon-MM register file.
//   Ports:
//     clk         in   system clock
//     reset_n     in   asynchronous active-low reset
//     address     in   register select (0 CTRL, 1 BRIGHT, 2 BLINK_DIV, 3 STATUS)
//     chipselect  in   slave select
//     write_n     in   write strobe, active-low
//     writedata   in   write data
//     readdata    out  addressed register, combinational, independent of chipselect
//     seg_in      in   segment pattern, 1 = segment lit
//     seg_out     out  registered drive to the HEX pins
module hex_seg_driver
    import hex_seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       chipselect,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic [6:0] seg_in,
    output logic [6:0] seg_out
);

    logic [2:0] r_ctrl;
    logic [3:0] r_bright;
    logic [7:0] r_blink_div;
    logic [3:0] r_pwm_cnt;
    logic [7:0] r_blink_cnt;
    logic       r_blink_phase;
    logic [6:0] r_seg_out;

    logic       w_tick;
    logic       w_wr;
    logic       w_wr_div;
    logic       w_pwm_on;
    logic [7:0] w_blink_last;
    logic [6:0] w_lit;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    assign w_wr     = chipselect && !write_n;
    assign w_wr_div = w_wr && (address == ADDR_BLINK_DIV);

    // Register file; STATUS is read-only so address 3 has no write path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl      <= CTRL_RST;
            r_bright    <= BRIGHT_RST;
            r_blink_div <= BLINK_DIV_RST;
        end else if (w_wr) begin
            case (address)
                ADDR_CTRL:      r_ctrl      <= writedata[2:0];
                ADDR_BRIGHT:    r_bright    <= writedata[3:0];
                ADDR_BLINK_DIV: r_blink_div <= writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    // BRIGHT=15 is forced on: a 4-bit compare alone would leave one dark slot.
    assign w_pwm_on = (r_bright == 4'hF) || (r_pwm_cnt < r_bright);

    // BLINK_DIV=0 behaves like 1 (toggle on every tick).
    assign w_blink_last = (r_blink_div == 8'd0) ? 8'd0 : (r_blink_div - 8'd1);

    // A BLINK_DIV write outranks a coincident tick: counter restarts, no toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= BLINK_PHASE_RST;
        end else if (!r_ctrl[CTRL_BLINK_EN]) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_wr_div) begin
            r_blink_cnt   <= '0;
        end else if (w_tick) begin
            if (r_blink_cnt == w_blink_last) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= !r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 8'd1;
            end
        end
    end

    assign w_lit = (r_ctrl[CTRL_ENABLE] && w_pwm_on &&
                    (!r_ctrl[CTRL_BLINK_EN] || r_blink_phase)) ? seg_in : 7'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg_out <= SEG_OUT_RST;
        end else begin
            r_seg_out <= r_ctrl[CTRL_INVERT] ? ~w_lit : w_lit;
        end
    end

    assign seg_out = r_seg_out;

    always_comb begin
        readdata = 8'h00;
        case (address)
            ADDR_CTRL:      readdata = {5'd0, r_ctrl};
            ADDR_BRIGHT:    readdata = {4'd0, r_bright};
            ADDR_BLINK_DIV: readdata = r_blink_div;
            ADDR_STATUS:    readdata = {6'd0, w_pwm_on, r_blink_phase};
            default:        readdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_hex_seg_driver.sv
module tb_hex_seg_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [6:0] seg_in;
    logic [6:0] seg_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: kind 0 = seg_out, kind 1 = readdata
    bit         q_kind[$];
    logic [7:0] q_exp[$];
    string      q_name[$];

    logic [7:0] rst_rd [4] = '{8'h05, 8'h0F, 8'hFA, 8'h03};

    always #5 clk = ~clk;

    hex_seg_driver #(.PRESCALE(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_in     (seg_in),
        .seg_out    (seg_out)
    );

    task automatic exp_seg(input logic [6:0] e, input string nm);
        q_kind.push_back(1'b0); q_exp.push_back({1'b0, e}); q_name.push_back(nm);
    endtask

    task automatic exp_rd(input logic [7:0] e, input string nm);
        q_kind.push_back(1'b1); q_exp.push_back(e); q_name.push_back(nm);
    endtask

    task automatic drive(input bit wr, input logic [1:0] a, input logic [7:0] d);
        chipselect = wr; write_n = ~wr; address = a; writedata = d;
    endtask

    // Hand-derived blink phase after edge k of the blink run (DIV=2, then
    // rewrite at tick 40 -> no toggle, then DIV=0 from edge 49).
    function automatic bit phase_c(input int k);
        return !((k >= 8 && k <= 15) || (k >= 24 && k <= 31) ||
                 (k >= 48 && k <= 51) || (k >= 56 && k <= 59));
    endfunction

    // BRIGHT after edge k of the PWM run.
    function automatic logic [3:0] bright_e(input int k);
        if (k < 2)  return 4'd15;
        if (k < 35) return 4'd4;
        if (k < 52) return 4'd0;
        return 4'd15;
    endfunction

    function automatic bit pwm_e(input int k);
        logic [3:0] b;
        logic [3:0] c;
        b = bright_e(k);
        c = 4'(k);
        return (b == 4'd15) || (c < b);
    endfunction

    // Monitor: outputs are checked 1 time unit after each rising edge.
    initial begin : monitor
        bit         k;
        logic [7:0] e;
        logic [7:0] got;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            while (q_kind.size() != 0) begin
                k   = q_kind.pop_front();
                e   = q_exp.pop_front();
                nm  = q_name.pop_front();
                got = k ? readdata : {1'b0, seg_out};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %02h expected %02h", nm, got, e);
                end
            end
        end
    end

    initial begin : stim
        int waits;
        reset_n = 1'b0;
        seg_in  = 7'h3F;
        drive(1'b0, 2'd0, 8'h00);

        // Reset state
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address = 2'(i);
            exp_seg(7'h7F, $sformatf("rst_seg_%0d", i));
            exp_rd(rst_rd[i], $sformatf("rst_reg_%0d", i));
        end
        @(negedge clk); reset_n = 1'b1; address = 2'd0;
        exp_seg(7'h40, "rel_inverted"); exp_rd(8'h05, "rel_ctrl");
        @(negedge clk); seg_in = 7'h06; exp_seg(7'h79, "inv_06");

        // Non-inverted pass-through, one-cycle lag
        @(negedge clk); drive(1'b1, 2'd0, 8'h01);
        exp_seg(7'h79, "wr_ctrl_edge"); exp_rd(8'h01, "ctrl_rd");
        @(negedge clk); drive(1'b0, 2'd0, 8'h00); exp_seg(7'h06, "pass_06");
        @(negedge clk); seg_in = 7'h5B; exp_seg(7'h5B, "pass_5b");
        @(negedge clk); seg_in = 7'h3F; exp_seg(7'h3F, "pass_3f");
        @(negedge clk); drive(1'b1, 2'd3, 8'hFF); exp_rd(8'h03, "status_ro");
        @(negedge clk); drive(1'b1, 2'd0, 8'hF9);
        exp_rd(8'h01, "ctrl_discard"); exp_seg(7'h3F, "pass_3f_b");
        @(negedge clk); drive(1'b1, 2'd1, 8'hF4); exp_rd(8'h04, "bright_discard");

        // Blink run
        @(negedge clk); drive(1'b0, 2'd0, 8'h00); reset_n = 1'b0;
        exp_seg(7'h7F, "rst2_seg");
        seg_in = 7'h06;
        for (int k = 1; k <= 58; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            if (k == 1) begin
                drive(1'b1, 2'd2, 8'h02); exp_rd(8'h02, "div_rd");
            end else if (k == 2) begin
                drive(1'b1, 2'd0, 8'h03); exp_rd(8'h03, "ctrl_blink_rd");
            end else if (k == 40) begin
                drive(1'b1, 2'd2, 8'h02); exp_rd(8'h02, "div_tick_rd");
            end else if (k == 49) begin
                drive(1'b1, 2'd2, 8'h00); exp_rd(8'h00, "div0_rd");
            end else begin
                drive(1'b0, 2'd3, 8'h00);
                exp_rd({6'd0, 1'b1, phase_c(k)}, $sformatf("blink_status_%0d", k));
            end
            exp_seg((k <= 2) ? 7'h79 : (phase_c(k - 1) ? 7'h06 : 7'h00),
                    $sformatf("blink_seg_%0d", k));
        end

        // Reset mid-blink (phase currently 0)
        @(negedge clk); drive(1'b0, 2'd3, 8'h00); reset_n = 1'b0;
        exp_seg(7'h7F, "midblink_seg"); exp_rd(8'h03, "midblink_status");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); address = 2'(i);
            exp_seg(7'h7F, $sformatf("midblink_rst_seg_%0d", i));
            exp_rd(rst_rd[i], $sformatf("midblink_reg_%0d", i));
        end

        // PWM run: BRIGHT 4, then 0, then 15
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            if (k == 1) begin
                drive(1'b1, 2'd0, 8'h01); exp_rd(8'h01, "pwm_ctrl_rd");
            end else if (k == 2) begin
                drive(1'b1, 2'd1, 8'h04); exp_rd(8'h04, "bright4_rd");
            end else if (k == 35) begin
                drive(1'b1, 2'd1, 8'h00); exp_rd(8'h00, "bright0_rd");
            end else if (k == 52) begin
                drive(1'b1, 2'd1, 8'h0F); exp_rd(8'h0F, "bright15_rd");
            end else begin
                drive(1'b0, 2'd3, 8'h00);
                exp_rd({6'd0, pwm_e(k), 1'b1}, $sformatf("pwm_status_%0d", k));
            end
            exp_seg((k == 1) ? 7'h79 : (pwm_e(k - 1) ? 7'h06 : 7'h00),
                    $sformatf("pwm_seg_%0d", k));
        end

        @(negedge clk); drive(1'b0, 2'd0, 8'h00);
        waits = 0;
        while (q_kind.size() != 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (q_kind.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", q_kind.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
